// File: rtl/shift_pipe8_if.sv
// Handshake/data bundle for shift_pipe8.
//   in_valid/in_ready : operand side handshake; din, shamt, dir, mode travel with it.
//   out_valid/out_ready: result side handshake; dout carries the result.
//   op_count           : number of results delivered, wraps at 8 bits.
// master = operand source / result consumer, slave = the shifter.
interface shift_pipe8_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             dir;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic [7:0]       op_count;

    modport master (
        output in_valid, din, shamt, dir, mode, out_ready,
        input  in_ready, out_valid, dout, op_count
    );

    modport slave (
        input  in_valid, din, shamt, dir, mode, out_ready,
        output in_ready, out_valid, dout, op_count
    );
endinterface

// File: rtl/shift_pipe8.sv
// Registered barrel shifter, one pipeline stage per shift-amount bit.
// Stage k conditionally shifts by 2^k (pass / zero fill / sign fill / rotate),
// so an accepted operand reaches dout after SHW rising edges.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; clears all stages and op_count
//   bus  - slave side of shift_pipe8_if (operand handshake, result handshake,
//          op_count)
// mode: 00 logical, 01 arithmetic, 10 rotate, 11 same as logical.
// dir : 0 left, 1 right. Arithmetic fill applies only to right shifts.
module shift_pipe8 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = 3
) (
    input logic        clk,
    input logic        rst,
    shift_pipe8_if.slave bus
);

    // Per-stage register views, stage SHW-1 is the output register.
    logic [SHW-1:0][WIDTH-1:0] st_d;
    logic [SHW-1:0][SHW-1:0]   st_sh;
    logic [SHW-1:0][1:0]       st_mode;
    logic [SHW-1:0]            st_v;
    logic [SHW-1:0]            st_dir;
    logic [SHW-1:0]            st_sign;
    logic [SHW-1:0]            adv;

    logic [7:0] op_count_q;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned S = 2 ** k;

        logic [WIDTH-1:0] src_d;
        logic [WIDTH-1:0] shifted;
        logic [SHW-1:0]   src_sh;
        logic [1:0]       src_mode;
        logic             src_v;
        logic             src_dir;
        logic             src_sign;

        logic [WIDTH-1:0] d_q;
        logic [SHW-1:0]   sh_q;
        logic [1:0]       mode_q;
        logic             v_q;
        logic             dir_q;
        logic             sign_q;

        // A stage may load when it is empty or some stage downstream of it is
        // empty or the consumer is taking the result; flattened so the chain
        // has no self-dependency.
        assign adv[k] = bus.out_ready | ~(&st_v[SHW-1:k]);

        if (k == 0) begin : g_src_in
            assign src_d    = bus.din;
            assign src_sh   = bus.shamt;
            assign src_mode = bus.mode;
            assign src_v    = bus.in_valid;
            assign src_dir  = bus.dir;
            assign src_sign = bus.din[WIDTH-1];
        end else begin : g_src_prev
            assign src_d    = st_d[k-1];
            assign src_sh   = st_sh[k-1];
            assign src_mode = st_mode[k-1];
            assign src_v    = st_v[k-1];
            assign src_dir  = st_dir[k-1];
            assign src_sign = st_sign[k-1];
        end

        always_comb begin
            shifted = src_d;
            if (src_sh[k]) begin
                if (src_dir) begin
                    unique case (src_mode)
                        2'b01:   shifted = (src_d >> S) |
                                           (~({WIDTH{1'b1}} >> S) & {WIDTH{src_sign}});
                        2'b10:   shifted = (src_d >> S) | (src_d << (WIDTH - S));
                        default: shifted = src_d >> S;
                    endcase
                end else begin
                    unique case (src_mode)
                        2'b10:   shifted = (src_d << S) | (src_d >> (WIDTH - S));
                        default: shifted = src_d << S;
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                d_q    <= '0;
                sh_q   <= '0;
                mode_q <= '0;
                dir_q  <= 1'b0;
                sign_q <= 1'b0;
            end else if (adv[k]) begin
                v_q    <= src_v;
                d_q    <= shifted;
                sh_q   <= src_sh;
                mode_q <= src_mode;
                dir_q  <= src_dir;
                sign_q <= src_sign;
            end
        end

        assign st_v[k]    = v_q;
        assign st_d[k]    = d_q;
        assign st_sh[k]   = sh_q;
        assign st_mode[k] = mode_q;
        assign st_dir[k]  = dir_q;
        assign st_sign[k] = sign_q;
    end

    // Control carried into the output register has no further consumer.
    logic unused_last_ctrl;
    assign unused_last_ctrl = ^{st_sh[SHW-1], st_mode[SHW-1], st_dir[SHW-1], st_sign[SHW-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (st_v[SHW-1] && bus.out_ready) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = st_v[SHW-1];
    assign bus.dout      = st_d[SHW-1];
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_shift_pipe8.sv
module tb_shift_pipe8;

    localparam int unsigned W  = 8;
    localparam int unsigned SH = 3;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       r;
        logic [1:0] m;
        logic [7:0] e;
    } vec_t;

    localparam vec_t TBL [8] = '{
        '{8'h96, 3'd3, 1'b1, 2'b00, 8'h12},
        '{8'h96, 3'd3, 1'b1, 2'b01, 8'hF2},
        '{8'h96, 3'd3, 1'b1, 2'b10, 8'hD2},
        '{8'h96, 3'd5, 1'b0, 2'b10, 8'hD2},
        '{8'h96, 3'd1, 1'b1, 2'b10, 8'h4B},
        '{8'h96, 3'd0, 1'b0, 2'b01, 8'h96},
        '{8'h96, 3'd3, 1'b1, 2'b11, 8'h12},
        '{8'h96, 3'd0, 1'b1, 2'b10, 8'h96}
    };

    logic clk;
    logic rst;

    shift_pipe8_if #(.WIDTH(W), .SHW(SH)) bus ();

    shift_pipe8 #(.WIDTH(W), .SHW(SH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors;
    int         miscompares;
    int         cyc;
    logic       acc;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-word reference: shift the operand by the full amount at once.
    function automatic logic [7:0] ref_shift(logic [7:0] d, int sh, logic right, logic [1:0] md);
        logic [15:0] dd;
        logic [7:0]  r;
        if (md == 2'b10) begin
            dd = right ? ({d, d} >> sh) : ({d, d} << sh);
            r  = right ? dd[7:0] : dd[15:8];
        end else if (right && md == 2'b01) begin
            r = $signed(d) >>> sh;
        end else begin
            r = right ? (d >> sh) : (d << sh);
        end
        return r;
    endfunction

    // Advance one clock; records accepted operands (as model results) and
    // delivered results just before the edge.
    task automatic tick();
        #1;
        acc = !rst && bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back(ref_shift(bus.din, int'(bus.shamt), bus.dir, bus.mode));
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.dout);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_results(int n, int budget);
        for (int t = 0; t < budget && got_q.size() < n; t++) tick();
    endtask

    task automatic flush_queues();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic set_op(logic [7:0] d, logic [2:0] s, logic r, logic [1:0] m);
        bus.din   = d;
        bus.shamt = s;
        bus.dir   = r;
        bus.mode  = m;
    endtask

    task automatic set_rand_op();
        set_op(8'($urandom), 3'($urandom), 1'($urandom), 2'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op(8'h00, 3'd0, 1'b0, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.dout !== 8'h00) begin
            miscompares++; $display("FAIL reset_dout: got %h expected 00", bus.dout);
        end
        vectors++;
        if (bus.op_count !== 8'd0) begin
            miscompares++; $display("FAIL reset_op_count: got %0d expected 0", bus.op_count);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        flush_queues();
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        set_op(8'h96, 3'd3, 1'b0, 2'b00);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL lat_n0_valid: got %b expected 0", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL lat_n1_valid: got %b expected 0", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.dout !== 8'hB0) begin
            miscompares++;
            $display("FAIL lat_n2_result: got valid=%b dout=%h expected valid=1 dout=b0",
                     bus.out_valid, bus.dout);
        end
        tick();
        vectors++;
        if (bus.op_count !== 8'd1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_count: got count=%0d valid=%b expected count=1 valid=0",
                     bus.op_count, bus.out_valid);
        end
        flush_queues();
    endtask

    task automatic test_directed();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_op(TBL[i].d, TBL[i].s, TBL[i].r, TBL[i].m);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        wait_results(8, 12);
        vectors++;
        if (got_q.size() != 8) begin
            miscompares++; $display("FAIL dir_count: got %0d results expected 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got_q[i] !== TBL[i].e || got_cyc[i] != got_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL dir_vec%0d: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_q[i], got_cyc[i], TBL[i].e, got_cyc[0] + i);
                end
            end
        end
        flush_queues();
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt0;
        int nacc;
        cnt0 = bus.op_count;
        nacc = 0;
        bus.out_ready = 1'b0;
        for (int t = 0; t < 20 && nacc < 3; t++) begin
            set_rand_op();
            bus.in_valid = 1'b1;
            tick();
            if (acc) nacc++;
        end
        set_rand_op();
        vectors++;
        if (nacc != 3 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: got accepts=%0d in_ready=%b out_valid=%b expected 3 0 1",
                     nacc, bus.in_ready, bus.out_valid);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            vectors++;
            if (acc || bus.dout !== exp_q[0] || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got acc=%b dout=%h in_ready=%b expected 0 %h 0",
                         t, acc, bus.dout, bus.in_ready, exp_q[0]);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (!acc) begin
            miscompares++; $display("FAIL bp_refill: got acc=0 expected acc=1");
        end
        bus.in_valid = 1'b0;
        wait_results(4, 10);
        vectors++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results expected 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] != got_cyc[0] + i) begin
                    miscompares++;
                    $display("FAIL bp_res%0d: got %h at cycle %0d expected %h at cycle %0d",
                             i, got_q[i], got_cyc[i], exp_q[i], got_cyc[0] + i);
                end
            end
        end
        vectors++;
        if (bus.op_count !== 8'(cnt0 + 8'd4)) begin
            miscompares++;
            $display("FAIL bp_op_count: got %0d expected %0d", bus.op_count, 8'(cnt0 + 8'd4));
        end
        flush_queues();
    endtask

    task automatic test_reset_flush();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_rand_op();
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.dout !== 8'h00 || bus.op_count !== 8'd0) begin
            miscompares++;
            $display("FAIL rf_clear: got valid=%b dout=%h count=%0d expected 0 00 0",
                     bus.out_valid, bus.dout, bus.op_count);
        end
        flush_queues();
        for (int t = 0; t < 5; t++) tick();
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++; $display("FAIL rf_discard: got %0d results expected 0", got_q.size());
        end
        set_op(8'h5A, 3'd2, 1'b1, 2'b01);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rf_lat_early: got valid=%b expected 0", bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.dout !== 8'h16) begin
            miscompares++;
            $display("FAIL rf_lat_result: got valid=%b dout=%h expected 1 16",
                     bus.out_valid, bus.dout);
        end
        tick();
        flush_queues();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush_queues();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            set_rand_op();
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        wait_results(256, 10);
        vectors++;
        if (got_q.size() != 256 || exp_q.size() != 256) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d results expected 256", got_q.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL wrap_res%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (bus.op_count !== 8'd0) begin
            miscompares++; $display("FAIL wrap_op_count: got %0d expected 0", bus.op_count);
        end
        flush_queues();
    endtask

    task automatic test_random();
        logic [7:0] cnt0;
        logic [7:0] prev;
        logic       stalled;
        int         n;
        cnt0 = bus.op_count;
        for (int t = 0; t < 400; t++) begin
            set_rand_op();
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            #1;
            stalled = bus.out_valid && !bus.out_ready;
            prev    = bus.dout;
            tick();
            if (stalled) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.dout !== prev) begin
                    miscompares++;
                    $display("FAIL rnd_stall%0d: got valid=%b dout=%h expected 1 %h",
                             t, bus.out_valid, bus.dout, prev);
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = exp_q.size();
        wait_results(n, 10);
        vectors++;
        if (got_q.size() != n) begin
            miscompares++;
            $display("FAIL rnd_count: got %0d results expected %0d", got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL rnd_res%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (bus.op_count !== 8'(cnt0 + 8'(n))) begin
            miscompares++;
            $display("FAIL rnd_op_count: got %0d expected %0d", bus.op_count, 8'(cnt0 + 8'(n)));
        end
        flush_queues();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        acc         = 1'b0;
        rst         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_op(8'h00, 3'd0, 1'b0, 2'b00);
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_reset_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
